// File: rtl/demux_1_to_2_buf_if.sv
// Handshake bundle between a single source and the two buffered sink channels of
// demux_1_to_2_buf. The source/testbench side uses master and the demux uses slave.
interface demux_1_to_2_buf_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             d_ready;
    logic             sel;
    logic             mode;
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;
    logic             q0_valid;
    logic             q1_valid;
    logic             q0_ack;
    logic             q1_ack;

    modport master (
        output d, d_valid, sel, mode, q0_ack, q1_ack,
        input  d_ready, q0, q1, q0_valid, q1_valid
    );

    modport slave (
        input  d, d_valid, sel, mode, q0_ack, q1_ack,
        output d_ready, q0, q1, q0_valid, q1_valid
    );
endinterface

// File: rtl/demux_1_to_2_buf.sv
// 1-to-2 demultiplexer with a one-word buffer per channel, manual or round-robin routing.
// Define DEMUX_1_TO_2_BUF_CNT_EN to add saturating per-channel push counters cnt0/cnt1.
module demux_1_to_2_buf #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    demux_1_to_2_buf_if.slave bus
`ifdef DEMUX_1_TO_2_BUF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);
    localparam int NCH = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    logic [NCH-1:0]   ack;
    logic [NCH-1:0]   full;
    logic [NCH-1:0]   push;
    logic [WIDTH-1:0] q_data [NCH];
    logic             tgt;
    logic             d_ready;
    logic             xfer;
    logic             rr_q;
    logic             rr_d;

    assign ack     = {bus.q1_ack, bus.q0_ack};
    assign tgt     = bus.mode ? rr_q : bus.sel;
    // A full target can still accept when its sink drains in the same cycle.
    assign d_ready = !full[tgt] || ack[tgt];
    assign xfer    = bus.d_valid && d_ready;

    assign bus.d_ready  = d_ready;
    assign bus.q0       = q_data[0];
    assign bus.q1       = q_data[1];
    assign bus.q0_valid = full[0];
    assign bus.q1_valid = full[1];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        state_t           state_q;
        state_t           state_d;
        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] data_d;
        logic             pop;

        assign push[gi] = xfer && (tgt == 1'(gi));
        assign pop      = (state_q == FULL) && ack[gi];

        always_comb begin
            state_d = state_q;
            data_d  = data_q;
            case (state_q)
                EMPTY:   if (push[gi]) state_d = FULL;
                FULL:    if (pop && !push[gi]) state_d = EMPTY;
                default: state_d = EMPTY;
            endcase
            // Data is left in place on pop so qN keeps showing the last word.
            if (push[gi]) data_d = bus.d;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= EMPTY;
                data_q  <= '0;
            end else begin
                state_q <= state_d;
                data_q  <= data_d;
            end
        end

        assign full[gi]   = (state_q == FULL);
        assign q_data[gi] = data_q;
    end

    // Pointer is forced to channel 0 whenever manual mode is selected.
    always_comb begin
        rr_d = rr_q;
        if (!bus.mode) begin
            rr_d = 1'b0;
        end else if (xfer) begin
            rr_d = ~rr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

`ifdef DEMUX_1_TO_2_BUF_CNT_EN
    logic [CNT_W-1:0] cnt_out [NCH];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (push[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_out[gi] = cnt_q;
    end

    assign cnt0 = cnt_out[0];
    assign cnt1 = cnt_out[1];
`endif
endmodule
